// File: rtl/program_loader_if.sv
// Byte-stream, program-RAM write port and session status of the boot loader.
// Ports: start/byte_in/byte_valid in, byte_ready back; pram_* write bus; cpu_hold/busy/done/error/words_written status.
// master = the host feeding the stream, slave = the loader.
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] pram_addr;
    logic [31:0]       pram_data;
    logic              pram_write_enable;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_written;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, pram_addr, pram_data, pram_write_enable,
               cpu_hold, busy, done, error, words_written
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, pram_addr, pram_data, pram_write_enable,
               cpu_hold, busy, done, error, words_written
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: framed byte stream (count, big-endian words, XOR checksum) -> one program RAM write per word.
// Latency: 4th byte of a word at edge T -> write strobe in cycle T+1; checksum byte at C -> done in C+1.
// Backpressure: byte_ready is low in IDLE and during the single WRITE cycle; the stream may stall any time.
// Ports: clk, rst (async active-low), lb (slave side of program_loader_if).
module program_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    program_loader_if.slave lb
);
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   cnt_t;
    typedef enum logic [2:0] {IDLE, LEN, COLLECT, WRITE, CHECK} state_t;

    // A length byte of zero stands for a full RAM image.
    localparam cnt_t FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t      state_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_q;       // first three bytes of the word being assembled
    logic [7:0]  chk_q;
    cnt_t        target_q;
    addr_t       addr_q;       // address of the next word to write
    addr_t       pram_addr_q;
    logic [31:0] pram_data_q;
    logic        we_q;
    logic        busy_q;
    logic        hold_q;
    logic        done_q;
    logic        err_q;
    cnt_t        ww_q;

    logic        byte_ready;
    logic        xfer;
    cnt_t        target_d;
    cnt_t        ww_d;

    assign byte_ready = (state_q == LEN) || (state_q == COLLECT) || (state_q == CHECK);
    assign xfer       = lb.byte_valid && byte_ready;
    assign target_d   = (lb.byte_in == 8'd0) ? FULL_CNT : cnt_t'(lb.byte_in);
    assign ww_d       = ww_q + cnt_t'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            chk_q       <= '0;
            target_q    <= '0;
            addr_q      <= '0;
            pram_addr_q <= '0;
            pram_data_q <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ww_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lb.start) begin
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        ww_q       <= '0;
                        chk_q      <= '0;
                        byte_cnt_q <= '0;
                        addr_q     <= BASE_ADDR;
                        busy_q     <= 1'b1;
                        hold_q     <= 1'b1;
                        state_q    <= LEN;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        target_q <= target_d;
                        state_q  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        chk_q      <= chk_q ^ lb.byte_in;
                        word_q     <= {word_q[15:0], lb.byte_in};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Capture address and data now so both are stable for the whole strobe cycle.
                            pram_data_q <= {word_q, lb.byte_in};
                            pram_addr_q <= addr_q;
                            addr_q      <= addr_q + addr_t'(1);
                            we_q        <= 1'b1;
                            state_q     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    we_q    <= 1'b0;
                    ww_q    <= ww_d;
                    state_q <= (ww_d == target_q) ? CHECK : COLLECT;
                end
                CHECK: begin
                    if (xfer) begin
                        err_q   <= (lb.byte_in != chk_q);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lb.byte_ready        = byte_ready;
    assign lb.pram_addr         = pram_addr_q;
    assign lb.pram_data         = pram_data_q;
    assign lb.pram_write_enable = we_q;
    assign lb.cpu_hold          = hold_q;
    assign lb.busy              = busy_q;
    assign lb.done              = done_q;
    assign lb.error             = err_q;
    assign lb.words_written     = ww_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two loaders (base 0x00 and 0xFE) share one random byte stream and are
// compared every cycle against a byte-counting stream model, plus literal end-of-session checks.
module tb_program_loader;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(AW)) if0 ();
    program_loader_if #(.ADDR_W(AW)) if1 ();

    assign if1.start      = if0.start;
    assign if1.byte_in    = if0.byte_in;
    assign if1.byte_valid = if0.byte_valid;

    program_loader #(.ADDR_W(AW), .BASE_ADDR(8'h00)) dut0 (.clk(clk), .rst(rst), .lb(if0.slave));
    program_loader #(.ADDR_W(AW), .BASE_ADDR(8'hFE)) dut1 (.clk(clk), .rst(rst), .lb(if1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stream model ----------------
    bit          m_busy, m_done, m_err, m_we;
    int          m_ww, m_nb, m_target;
    logic [31:0] m_word, m_data;
    logic [7:0]  m_chk;
    logic [7:0]  m_addr [2];
    int          base [2] = '{0, 254};

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
        m_ww = 0; m_nb = 0; m_target = 0;
        m_word = '0; m_data = '0; m_chk = '0;
        m_addr[0] = '0; m_addr[1] = '0;
    endtask

    task automatic cmp_dut(input int d, input logic rdy, input logic we, input logic hold,
                           input logic bsy, input logic dn, input logic er,
                           input logic [8:0] ww, input logic [7:0] ad, input logic [31:0] dt);
        string t;
        t = (d == 0) ? "d0" : "d1";
        check({t, "_byte_ready"}, 64'(rdy),  64'(m_busy && !m_we));
        check({t, "_write_en"},   64'(we),   64'(m_we));
        check({t, "_cpu_hold"},   64'(hold), 64'(m_busy));
        check({t, "_busy"},       64'(bsy),  64'(m_busy));
        check({t, "_done"},       64'(dn),   64'(m_done));
        check({t, "_error"},      64'(er),   64'(m_err));
        check({t, "_words"},      64'(ww),   64'(m_ww));
        check({t, "_pram_addr"},  64'(ad),   64'(m_addr[d]));
        check({t, "_pram_data"},  64'(dt),   64'(m_data));
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) model_reset();
            cmp_dut(0, if0.byte_ready, if0.pram_write_enable, if0.cpu_hold, if0.busy, if0.done,
                    if0.error, if0.words_written, if0.pram_addr, if0.pram_data);
            cmp_dut(1, if1.byte_ready, if1.pram_write_enable, if1.cpu_hold, if1.busy, if1.done,
                    if1.error, if1.words_written, if1.pram_addr, if1.pram_data);
            if (rst) begin
                bit         sacc, xf;
                logic [7:0] b;
                sacc = if0.start && !m_busy;
                xf   = if0.byte_valid && m_busy && !m_we;
                b    = if0.byte_in;
                if (m_we) begin
                    m_we = 0;
                    m_ww++;
                end
                if (xf) begin
                    if (m_nb == 0) begin
                        m_target = (b == 8'd0) ? 256 : int'(b);
                    end else if (m_nb <= 4 * m_target) begin
                        m_word = {m_word[23:0], b};
                        m_chk  = m_chk ^ b;
                        if (m_nb % 4 == 0) begin
                            m_we   = 1;
                            m_data = m_word;
                            for (int d = 0; d < 2; d++) m_addr[d] = 8'((base[d] + m_ww) % 256);
                        end
                    end else begin
                        m_done = 1;
                        m_err  = (b != m_chk);
                        m_busy = 0;
                    end
                    m_nb++;
                end
                if (sacc) begin
                    m_busy = 1; m_done = 0; m_err = 0;
                    m_ww = 0; m_nb = 0; m_chk = '0; m_word = '0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] words [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) tick();
        if0.byte_valid = 1'b1;
        if0.byte_in    = b;
        guard = 0;
        forever begin
            @(negedge clk);
            if (if0.byte_ready) break;
            guard++;
            if (guard > 50) begin
                check("byte_ready_timeout", 64'(if0.byte_ready), 64'd1);
                break;
            end
        end
        tick();
        if0.byte_valid = 1'b0;
        if0.byte_in    = 8'($urandom);
    endtask

    task automatic do_start(input bit with_byte);
        if0.start = 1'b1;
        if (with_byte) begin
            if0.byte_valid = 1'b1;
            if0.byte_in    = 8'hAA;
        end
        tick();
        if0.start      = 1'b0;
        if0.byte_valid = 1'b0;
    endtask

    // Sends one whole session; chk_xor != 0 corrupts the checksum byte.
    task automatic send_session(input int nfield, input int nw, input logic [7:0] chk_xor,
                                input int gmax, input bit inj_start, input bit start_byte);
        logic [7:0]  c;
        logic [31:0] w;
        c = '0;
        do_start(start_byte);
        send_byte(8'(nfield), $urandom_range(0, gmax));
        for (int i = 0; i < nw; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                if (inj_start && i == 0 && k == 2) do_start(0);
                c = c ^ w[31-8*k -: 8];
                send_byte(w[31-8*k -: 8], $urandom_range(0, gmax));
            end
        end
        send_byte(c ^ chk_xor, $urandom_range(0, gmax));
    endtask

    initial begin
        if0.start = 1'b0; if0.byte_valid = 1'b0; if0.byte_in = '0;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if0.start = 1'($urandom); if0.byte_valid = 1'($urandom); if0.byte_in = 8'($urandom);
        end
        tick();
        if0.start = 1'b0; if0.byte_valid = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        // Single word, start coinciding with a valid byte in IDLE.
        words[0] = 32'h12345678;
        send_session(1, 1, 8'h00, 0, 0, 1);
        check("single_done",  64'(if0.done), 64'd1);
        check("single_error", 64'(if0.error), 64'd0);
        check("single_words", 64'(if0.words_written), 64'd1);
        check("single_hold",  64'(if0.cpu_hold), 64'd0);
        check("single_data",  64'(if0.pram_data), 64'h12345678);
        check("single_addr0", 64'(if0.pram_addr), 64'h00);
        check("single_addr1", 64'(if1.pram_addr), 64'hFE);
        repeat (2) tick();

        // Three words with gaps; the 0xFE loader wraps FE, FF, 00.
        words[0] = 32'hDEADBEEF; words[1] = 32'h00000001; words[2] = 32'hFFFF0000;
        send_session(3, 3, 8'h00, 3, 0, 0);
        check("multi_words", 64'(if0.words_written), 64'd3);
        check("multi_addr0", 64'(if0.pram_addr), 64'h02);
        check("multi_wrap",  64'(if1.pram_addr), 64'h00);
        check("multi_data",  64'(if0.pram_data), 64'hFFFF0000);
        check("multi_error", 64'(if0.error), 64'd0);
        repeat (2) tick();

        // Checksum 09 instead of 08.
        words[0] = 32'h12345678;
        send_session(1, 1, 8'h01, 1, 0, 0);
        check("badchk_done",  64'(if0.done), 64'd1);
        check("badchk_error", 64'(if0.error), 64'd1);
        check("badchk_words", 64'(if0.words_written), 64'd1);
        check("badchk_data",  64'(if0.pram_data), 64'h12345678);
        repeat (2) tick();

        // Full image: length byte 0 -> 256 words.
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        send_session(0, 256, 8'h00, 0, 0, 0);
        check("full_words", 64'(if0.words_written), 64'd256);
        check("full_addr0", 64'(if0.pram_addr), 64'hFF);
        check("full_addr1", 64'(if1.pram_addr), 64'hFD);
        check("full_error", 64'(if0.error), 64'd0);
        repeat (2) tick();

        // Abort after two data bytes, then a clean single-word session with a start while busy.
        do_start(0);
        send_byte(8'd2, 0);
        send_byte(8'hAB, 1);
        send_byte(8'hCD, 0);
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(if0.busy), 64'd0);
        check("abort_hold", 64'(if0.cpu_hold), 64'd0);
        check("abort_data", 64'(if0.pram_data), 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        words[0] = 32'h12345678;
        send_session(1, 1, 8'h00, 2, 1, 0);
        check("restart_data",  64'(if0.pram_data), 64'h12345678);
        check("restart_addr",  64'(if0.pram_addr), 64'h00);
        check("restart_words", 64'(if0.words_written), 64'd1);
        check("restart_error", 64'(if0.error), 64'd0);
        repeat (2) tick();

        // Random sessions.
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            send_session(n, n, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                         4, 1'($urandom), 0);
            check("rand_done", 64'(if0.done), 64'd1);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
